// File: rtl/prog_delay_line.sv
// Runtime-programmable delay line: a circular buffer of MAX_DELAY samples whose
// read tap is placed D-1 entries behind the write pointer, with valid gating.
module prog_delay_line #(
    parameter int WIDTH         = 8,
    parameter int MAX_DELAY     = 90,
    parameter int DEFAULT_DELAY = 30,
    localparam int DW           = $clog2(MAX_DELAY + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             delay_ld,
    input  logic [DW-1:0]    delay_in,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             delay_err,
    output logic [DW-1:0]    active_delay
);

    localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam logic [AW-1:0] WP_LAST = AW'(MAX_DELAY - 1);
    localparam logic [AW-1:0] MAX_A   = AW'(MAX_DELAY);
    localparam logic [DW-1:0] MAX_D   = DW'(MAX_DELAY);
    localparam logic [DW-1:0] DEF_D   = DW'(DEFAULT_DELAY);

    logic [WIDTH-1:0] mem [MAX_DELAY];

    logic [AW-1:0]    wp_reg;
    logic [DW-1:0]    fill_reg;
    logic [DW-1:0]    delay_reg;
    logic             valid_reg;
    logic             err_reg;
    logic [WIDTH-1:0] data_reg;

    logic             load_ok;
    logic             load_bad;
    logic [DW-1:0]    delay_next;
    logic [DW-1:0]    fill_next;
    logic [AW-1:0]    back;
    logic [AW-1:0]    rd_addr;

    // A legal load takes effect in the same cycle, so the read tap and the
    // fill target already use the new delay when en coincides with the load.
    always_comb begin
        load_ok    = delay_ld && (delay_in != '0) && (delay_in <= MAX_D);
        load_bad   = delay_ld && !load_ok;
        delay_next = load_ok ? delay_in : delay_reg;
        back       = AW'(delay_next - DW'(1));
        // Result is always below MAX_DELAY, so modulo-2^AW wrap is exact.
        if (wp_reg >= back) begin
            rd_addr = wp_reg - back;
        end else begin
            rd_addr = wp_reg + (MAX_A - back);
        end
        fill_next = fill_reg;
        if (load_ok) begin
            fill_next = en ? DW'(1) : '0;
        end else if (en && (fill_reg != delay_reg)) begin
            fill_next = fill_reg + DW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wp_reg    <= '0;
            fill_reg  <= '0;
            delay_reg <= DEF_D;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            delay_reg <= delay_next;
            fill_reg  <= fill_next;
            valid_reg <= (fill_next == delay_next);
            err_reg   <= load_bad;
            if (en) begin
                wp_reg <= (wp_reg == WP_LAST) ? '0 : wp_reg + AW'(1);
            end
        end
    end

    // Storage and read register carry no reset; valid gating hides stale data.
    always_ff @(posedge clock) begin
        if (en && !reset) begin
            mem[wp_reg] <= din;
            data_reg    <= (delay_next == DW'(1)) ? din : mem[rd_addr];
        end
    end

    assign dout         = valid_reg ? data_reg : '0;
    assign dout_valid   = valid_reg;
    assign delay_err    = err_reg;
    assign active_delay = delay_reg;

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench for prog_delay_line: priming, reloads, stalls, illegal
// requests and mid-stream reset, with expected values computed per edge.
module tb_prog_delay_line;

    localparam int WIDTH         = 8;
    localparam int MAX_DELAY     = 90;
    localparam int DEFAULT_DELAY = 30;
    localparam int DW            = 7;

    logic             clock = 1'b0;
    logic             reset;
    logic             en;
    logic [WIDTH-1:0] din;
    logic             delay_ld;
    logic [DW-1:0]    delay_in;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             delay_err;
    logic [DW-1:0]    active_delay;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    prog_delay_line #(
        .WIDTH         (WIDTH),
        .MAX_DELAY     (MAX_DELAY),
        .DEFAULT_DELAY (DEFAULT_DELAY)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .en           (en),
        .din          (din),
        .delay_ld     (delay_ld),
        .delay_in     (delay_in),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .delay_err    (delay_err),
        .active_delay (active_delay)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // After the k-th enabled edge of priming with delay d, where sample i
    // carries value first+i-1, the line must show sample k-d+1 once k >= d.
    task automatic expect_out(input string tag, input int k, input int d, input logic [7:0] first);
        bit         v;
        logic [7:0] e;
        v = (k >= d);
        e = v ? 8'(first + 8'(k - d)) : 8'h00;
        check({tag, "_valid"}, 32'(dout_valid), 32'(v));
        check({tag, "_dout"}, 32'(dout), 32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          cnt;
        logic [DW-1:0] bad [2];
        bad[0] = 7'd0;
        bad[1] = 7'd91;

        reset = 1'b1; en = 1'b0; delay_ld = 1'b0; din = '0; delay_in = '0;
        tick();
        tick();
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_valid", 32'(dout_valid), 32'h0);
        check("rst_err", 32'(delay_err), 32'h0);
        check("rst_active", 32'(active_delay), 32'd30);
        reset = 1'b0;
        $display("txn reset: active_delay=%0d", active_delay);

        // Default delay priming with a continuous stream.
        en = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            din = 8'(i);
            tick();
            expect_out("p1", i, 30, 8'd1);
        end
        $display("txn default stream: 35 samples, dout=%0d", dout);

        // D = 1 load with en: output is the same-cycle input.
        delay_ld = 1'b1; delay_in = 7'd1; din = 8'hA5;
        tick();
        delay_ld = 1'b0;
        check("d1_dout", 32'(dout), 32'hA5);
        check("d1_valid", 32'(dout_valid), 32'h1);
        check("d1_active", 32'(active_delay), 32'd1);
        for (int i = 0; i < 5; i++) begin
            din = 8'(8'h10 + i);
            tick();
            check("d1_follow", 32'(dout), 32'(8'h10 + i));
        end
        $display("txn load d=1: dout=0x%0h", dout);

        // Maximum delay across several pointer wraps.
        delay_in = 7'd90;
        for (int i = 1; i <= 300; i++) begin
            delay_ld = (i == 1);
            din = 8'(i);
            tick();
            expect_out("p90", i, 90, 8'd1);
        end
        delay_ld = 1'b0;
        check("d90_active", 32'(active_delay), 32'd90);
        $display("txn load d=90: 300 samples, dout=%0d", dout);

        // Load without en, then random stalls with D = 4.
        en = 1'b0; delay_ld = 1'b1; delay_in = 7'd4; din = 8'hEE;
        tick();
        delay_ld = 1'b0;
        check("ld_noen_valid", 32'(dout_valid), 32'h0);
        check("ld_noen_dout", 32'(dout), 32'h0);
        check("ld_noen_active", 32'(active_delay), 32'd4);
        cnt = 0;
        for (int c = 0; c < 80; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                en = 1'b1;
                cnt++;
                din = 8'(cnt);
            end else begin
                en = 1'b0;
                din = 8'hEE;
            end
            tick();
            expect_out("p4", cnt, 4, 8'd1);
        end
        $display("txn stall d=4: %0d enabled edges, dout=%0d", cnt, dout);

        // Mid-stream reload 30 -> 45, then illegal requests.
        en = 1'b1; delay_in = 7'd30;
        for (int i = 1; i <= 40; i++) begin
            delay_ld = (i == 1);
            din = 8'(i);
            tick();
            expect_out("p30", i, 30, 8'd1);
        end
        delay_in = 7'd45;
        for (int i = 1; i <= 50; i++) begin
            delay_ld = (i == 1);
            din = 8'(99 + i);
            tick();
            expect_out("p45", i, 45, 8'd100);
        end
        check("d45_active", 32'(active_delay), 32'd45);
        $display("txn reload d=45: dout=%0d", dout);
        k = 50;
        for (int b = 0; b < 2; b++) begin
            delay_ld = 1'b1; delay_in = bad[b];
            k++;
            din = 8'(99 + k);
            tick();
            check("bad_err", 32'(delay_err), 32'h1);
            check("bad_active", 32'(active_delay), 32'd45);
            expect_out("bad", k, 45, 8'd100);
            delay_ld = 1'b0;
            k++;
            din = 8'(99 + k);
            tick();
            check("bad_err_clr", 32'(delay_err), 32'h0);
            expect_out("bad_after", k, 45, 8'd100);
            $display("txn illegal load %0d: active_delay=%0d", bad[b], active_delay);
        end

        // Reset while streaming at D = 60; a coincident load must be ignored.
        delay_in = 7'd60;
        for (int i = 1; i <= 65; i++) begin
            delay_ld = (i == 1);
            din = 8'(i);
            tick();
            expect_out("p60", i, 60, 8'd1);
        end
        reset = 1'b1; delay_ld = 1'b1; delay_in = 7'd5; din = 8'h77;
        tick();
        reset = 1'b0; delay_ld = 1'b0;
        check("mrst_dout", 32'(dout), 32'h0);
        check("mrst_valid", 32'(dout_valid), 32'h0);
        check("mrst_active", 32'(active_delay), 32'd30);
        check("mrst_err", 32'(delay_err), 32'h0);
        for (int i = 1; i <= 32; i++) begin
            din = 8'(200 + i);
            tick();
            expect_out("prst", i, 30, 8'd201);
        end
        $display("txn mid-stream reset: reprimed, dout=%0d", dout);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_delay_line.md
Name: prog_delay_line

Overview:
- Runtime-programmable, parametrised digital delay line for sample streams.
- Replaces the family of fixed 30/45/60/90-stage delay lines with one block whose depth is loaded at run time. Width and maximum depth are set by parameters.
- Adds clock-enable stalling, an output-valid flag that tracks priming after reset or reload, and rejection of illegal depth requests.
- Sits between the chip input bus and the output mux; one instance per delay channel.

Parameters:
WIDTH, 8, sample width in bits.
MAX_DELAY, 90, largest legal delay in enabled cycles; need not be a power of two.
DEFAULT_DELAY, 30, active delay after reset; must satisfy 1 <= DEFAULT_DELAY <= MAX_DELAY.
(Derived localparam DW = clog2(MAX_DELAY+1), the width of the delay request.)

Ports:
clock        in   1      single clock; all state changes on its rising edge.
reset        in   1      synchronous, active-high reset.
en           in   1      advance: when 1 at an edge, din is accepted and the line shifts one position.
din          in   WIDTH  input sample.
delay_ld     in   1      one-cycle load strobe for delay_in.
delay_in     in   DW     requested delay D.
dout         out  WIDTH  delayed sample; forced to 0 while dout_valid = 0.
dout_valid   out  1      1 once the line is primed with D samples since the last reset or accepted load.
delay_err    out  1      one-cycle pulse after an illegal load.
active_delay out  DW     currently applied D.

Behaviour:
- Clocking and reset: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: write pointer 0, fill counter 0, active_delay = DEFAULT_DELAY, dout 0, dout_valid 0, delay_err 0.
- Storage RAM/regfile is not reset. Stale contents are never visible because of valid gating.
- Reset has priority over en and delay_ld in the same cycle.
- Storage: circular buffer of MAX_DELAY entries.
  - Write pointer wp increments on each enabled edge.
  - Wrap is explicit: MAX_DELAY-1 -> 0 (no power-of-two assumption).
- Latency, at each edge with en = 1:
  - mem[wp] <= din.
  - If D = 1: dout <= din.
  - Otherwise: dout <= mem[(wp - (D-1)) mod MAX_DELAY].
  - Net effect: a sample accepted at enabled edge m appears on dout after enabled edge m+D-1. This is identical to a D-stage shift register.
- Stall: en = 0 freezes wp, fill, dout and dout_valid. Disabled cycles never count toward latency.
- Fill counter:
  - Increments on each enabled edge and saturates at D.
  - dout_valid is 1 from the edge at which fill reaches D.
  - While dout_valid = 0, dout drives 0.
- Load, delay_ld = 1:
  - Legal (1 <= delay_in <= MAX_DELAY): active_delay <= delay_in and fill is restarted. The line re-primes with the new D; old samples are never emitted under the new delay.
  - Illegal (0 or > MAX_DELAY): load ignored, active_delay and fill unchanged, delay_err = 1 for exactly the next cycle.
- Load and en in the same cycle: the load applies first, and that cycle's din is written and counts as sample 1 of the new delay (fill = 1).
  - If the new D = 1, dout_valid = 1 and dout = din after that edge.
  - A load with delay_in equal to active_delay still restarts priming.
- Load without en: fill = 0, dout_valid = 0 and dout = 0 after the edge.
- Reset mid-stream: the next cycle matches the post-reset state exactly. Priming restarts with DEFAULT_DELAY.
- Arithmetic: pointer subtraction is modulo MAX_DELAY. No width growth on data; dout is a pure copy of din.

Test Plan:
- Reset, then en = 1 continuously with din = 1,2,3,… (8-bit wrap). Required: dout_valid rises after the 30th enabled edge, with dout = 1 on that edge. dout = 0 on every earlier cycle.
- Load D = 1 with en, din = 0xA5. Required: the next cycle shows dout = 0xA5, dout_valid = 1. Then dout follows din with one cycle of latency.
- Load D = 90, feed 300 incrementing samples. Required: dout = din delayed by 89 further enabled edges across three pointer wraps; dout_valid rises on the 90th edge.
- D = 4 with a random en pattern (about 50% gaps), din incrementing only when en = 1. Required: dout sequence is contiguous 1,2,3,…; values hold during en = 0; latency is counted in enabled edges only.
- Mid-stream legal load 30 -> 45, then illegal loads 0 and 91. Required:
  - Legal load: dout_valid drops and dout = 0 for 44 enabled edges, then dout equals the first post-load sample; active_delay = 45.
  - Illegal loads: each gives a one-cycle delay_err pulse; active_delay stays 45 and dout_valid is unaffected.
- Assert reset while streaming with D = 60 and valid = 1. Required: the next cycle shows dout = 0, dout_valid = 0, active_delay = 30, and priming restarts from 0.
